// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: sole owner of the VRAM write port. Merges buffered PCU pen
// writes with a screen-clear sweep so that a pen write landing during a clear
// is never overwritten by that clear.
// Optional build macro CLR_RECT_EN: restricts the clear to a rectangle
// (clr_x0/clr_y0/clr_x1/clr_y1). Rectangle mode assumes AW = 16 ({y, x}).
module vram_wr_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_data,
    output logic          p_ready,
    output logic          p_drop,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
`ifdef CLR_RECT_EN
    input  logic [7:0]    clr_x0,
    input  logic [7:0]    clr_y0,
    input  logic [7:0]    clr_x1,
    input  logic [7:0]    clr_y1,
`endif
    output logic          clr_busy,
    output logic          clr_done,
    output logic          vram_we,
    output logic [AW-1:0] vram_a,
    output logic [DW-1:0] vram_d
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    // pen FIFO storage and bookkeeping
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          p_ready_reg;
    logic          p_drop_reg;

    // arbiter / clear state
    state_t        state_reg;
    logic [DW-1:0] clr_color_reg;
    logic          clr_busy_reg;
    logic          clr_done_reg;
    logic          vram_we_reg;
    logic [AW-1:0] vram_a_reg;
    logic [DW-1:0] vram_d_reg;

    // sweep position widened by one bit so the ordering compare never wraps
    logic [AW:0]   clr_pos;
    logic          clr_last;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          head_below;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          grant_pen;
    logic          grant_clr;

`ifdef CLR_RECT_EN
    logic [7:0]    cx_reg;
    logic [7:0]    cy_reg;
    logic [7:0]    rx0_reg;
    logic [7:0]    rx1_reg;
    logic [7:0]    ry1_reg;

    assign clr_pos  = {{(AW-15){1'b0}}, cy_reg, cx_reg};
    assign clr_last = (cx_reg == rx1_reg) && (cy_reg == ry1_reg);
`else
    logic [AW:0]   clr_ptr_reg;

    assign clr_pos  = clr_ptr_reg;
    assign clr_last = (clr_ptr_reg[AW-1:0] == {AW{1'b1}});
`endif

    assign push       = p_we && p_ready_reg;
    assign fifo_empty = (count_reg == '0);
    assign head_addr  = fifo_addr[rd_ptr_reg];
    assign head_data  = fifo_data[rd_ptr_reg];
    assign head_below = ({1'b0, head_addr} < clr_pos);
    assign pop        = grant_pen;

    assign p_ready  = p_ready_reg;
    assign p_drop   = p_drop_reg;
    assign clr_busy = clr_busy_reg;
    assign clr_done = clr_done_reg;
    assign vram_we  = vram_we_reg;
    assign vram_a   = vram_a_reg;
    assign vram_d   = vram_d_reg;

    // choose who owns the write port this cycle; a clear yields only to heads it has already passed
    always_comb begin
        grant_pen = 1'b0;
        grant_clr = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: grant_pen = !fifo_empty;
            S_CLEAR: begin
                if (!fifo_empty && head_below) begin
                    grant_pen = 1'b1;
                end else begin
                    grant_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // FIFO pointers, occupancy and the registered ready/drop flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            p_ready_reg <= 1'b0;
            p_drop_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg   <= count_next;
            p_ready_reg <= (count_next != CW'(FIFO_DEPTH));
            p_drop_reg  <= p_we && !p_ready_reg;
        end
    end

    // FIFO payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_reg] <= p_addr;
            fifo_data[wr_ptr_reg] <= p_data;
        end
    end

    // clear FSM plus the registered VRAM write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            clr_color_reg <= '0;
            clr_busy_reg  <= 1'b0;
            clr_done_reg  <= 1'b0;
            vram_we_reg   <= 1'b0;
            vram_a_reg    <= '0;
            vram_d_reg    <= '0;
`ifdef CLR_RECT_EN
            cx_reg        <= '0;
            cy_reg        <= '0;
            rx0_reg       <= '0;
            rx1_reg       <= '0;
            ry1_reg       <= '0;
`else
            clr_ptr_reg   <= '0;
`endif
        end else begin
            clr_done_reg <= 1'b0;
            vram_we_reg  <= grant_pen || grant_clr;
            if (grant_pen) begin
                vram_a_reg <= head_addr;
                vram_d_reg <= head_data;
            end else if (grant_clr) begin
                vram_a_reg <= clr_pos[AW-1:0];
                vram_d_reg <= clr_color_reg;
            end

            case (state_reg)
                S_IDLE: begin
                    if (clr_start) begin
                        clr_color_reg <= clr_color;
                        clr_busy_reg  <= 1'b1;
`ifdef CLR_RECT_EN
                        cx_reg  <= clr_x0;
                        cy_reg  <= clr_y0;
                        rx0_reg <= clr_x0;
                        rx1_reg <= clr_x1;
                        ry1_reg <= clr_y1;
                        // an empty rectangle completes without writing anything
                        if ((clr_x0 > clr_x1) || (clr_y0 > clr_y1)) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_CLEAR;
                        end
`else
                        clr_ptr_reg <= '0;
                        state_reg   <= S_CLEAR;
`endif
                    end
                end
                S_CLEAR: begin
                    if (grant_clr) begin
                        if (clr_last) begin
                            state_reg <= S_DONE;
                        end
`ifdef CLR_RECT_EN
                        if (cx_reg == rx1_reg) begin
                            cx_reg <= rx0_reg;
                            cy_reg <= cy_reg + 8'd1;
                        end else begin
                            cx_reg <= cx_reg + 8'd1;
                        end
`else
                        clr_ptr_reg <= clr_ptr_reg + (AW+1)'(1);
`endif
                    end
                end
                S_DONE: begin
                    clr_done_reg <= 1'b1;
                    clr_busy_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter: pen path, back-pressure, full clear with
// interleaved pen writes, ignored restart, reset mid-clear, optional rectangle.
`timescale 1ns/1ps
module tb_vram_wr_arbiter;
    localparam int AW = 16;
    localparam int DW = 12;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          p_we      = 1'b0;
    logic [AW-1:0] p_addr    = '0;
    logic [DW-1:0] p_data    = '0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          p_ready;
    logic          p_drop;
    logic          clr_busy;
    logic          clr_done;
    logic          vram_we;
    logic [AW-1:0] vram_a;
    logic [DW-1:0] vram_d;
`ifdef CLR_RECT_EN
    logic [7:0]    clr_x0 = '0;
    logic [7:0]    clr_y0 = '0;
    logic [7:0]    clr_x1 = '0;
    logic [7:0]    clr_y1 = '0;
`endif

    vram_wr_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .p_ready   (p_ready),
        .p_drop    (p_drop),
        .clr_start (clr_start),
        .clr_color (clr_color),
`ifdef CLR_RECT_EN
        .clr_x0    (clr_x0),
        .clr_y0    (clr_y0),
        .clr_x1    (clr_x1),
        .clr_y1    (clr_y1),
`endif
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vram_we   (vram_we),
        .vram_a    (vram_a),
        .vram_d    (vram_d)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // write monitor state
    logic [DW-1:0] vmem [0:65535];
    logic [DW-1:0] mon_color = '0;
    int            cyc = 0;
    int            clear_writes, seq_err, done_cnt, done_cyc, last_clr_cyc, bad_color;
    logic          busy_at_done;
    logic [AW-1:0] pen_a [$];
    logic [DW-1:0] pen_d [$];
    int            pen_at [$];
    logic [AW-1:0] clr_log [$];

    logic [15:0]   bp_addr [0:5] = '{16'hFFFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    logic [15:0]   rect_exp [0:5] = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
    int            guard;
    int            cw_at_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_mon();
        clear_writes = 0;
        seq_err      = 0;
        done_cnt     = 0;
        done_cyc     = -100;
        last_clr_cyc = 0;
        bad_color    = 0;
        busy_at_done = 1'b1;
        pen_a.delete();
        pen_d.delete();
        pen_at.delete();
        clr_log.delete();
    endtask

    // advance one clock and record what the write port did in that cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (vram_we) begin
            vmem[vram_a] = vram_d;
            if (vram_d == mon_color) begin
                if (32'(vram_a) != clear_writes) seq_err++;
                clr_log.push_back(vram_a);
                clear_writes++;
                last_clr_cyc = cyc;
            end else begin
                if (vram_d == 12'hFFF) bad_color++;
                pen_a.push_back(vram_a);
                pen_d.push_back(vram_d);
                pen_at.push_back(clear_writes);
            end
        end
        if (clr_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = clr_busy;
        end
    endtask

    initial begin
        reset_mon();

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_p_ready", p_ready, 0);
        check("rst_p_drop", p_drop, 0);
        check("rst_vram_we", vram_we, 0);
        check("rst_vram_a", vram_a, 0);
        check("rst_vram_d", vram_d, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_clr_done", clr_done, 0);
        rst = 1'b1;
        step();
        check("ready_after_rst", p_ready, 1);

        // ---- single pen write, idle ----
        p_we = 1'b1; p_addr = 16'h0102; p_data = 12'hF00;
        step();
        p_we = 1'b0;
        check("pen_no_write_at_accept", vram_we, 0);
        step();
        check("pen_we", vram_we, 1);
        check("pen_a", vram_a, 16'h0102);
        check("pen_d", vram_d, 12'hF00);
        step();
        check("pen_we_one_cycle", vram_we, 0);
        check("pen_a_hold", vram_a, 16'h0102);
        check("pen_d_hold", vram_d, 12'hF00);

        // ---- full clear with interleaved pen traffic ----
        reset_mon();
        mon_color = 12'h000;
        clr_color = 12'h000; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("clr_busy_start", clr_busy, 1);
        check("clr_no_write_at_start", vram_we, 0);
        step();
        check("clr_first_we", vram_we, 1);
        check("clr_first_a", vram_a, 16'h0000);
        guard = 0;
        while (clear_writes < 256 && guard < 2000) begin step(); guard++; end
        check("clr_reach_0100", clear_writes, 256);

        // pen below the sweep goes out at once, pen above waits for the sweep
        p_we = 1'b1; p_addr = 16'h0050; p_data = 12'hABC;
        step();
        p_addr = 16'h8000; p_data = 12'h0DE;
        step();
        p_we = 1'b0;
        check("ord_pen_count_early", pen_a.size(), 1);
        if (pen_a.size() >= 1) begin
            check("ord_0050_a", pen_a[0], 16'h0050);
            check("ord_0050_d", pen_d[0], 12'hABC);
            check("ord_0050_when", pen_at[0], 257);
        end
        guard = 0;
        while (clear_writes < 32'h9000 && guard < 40000) begin step(); guard++; end
        check("clr_reach_9000", clear_writes, 32'h9000);
        check("ord_pen_count_mid", pen_a.size(), 2);
        if (pen_a.size() >= 2) begin
            check("ord_8000_a", pen_a[1], 16'h8000);
            check("ord_8000_d", pen_d[1], 12'h0DE);
            check("ord_8000_after_clear", pen_at[1], 32'h8001);
        end

        // restart request mid-clear must be ignored
        clr_color = 12'hFFF; clr_start = 1'b1;
        step();
        clr_start = 1'b0; clr_color = 12'h000;
        check("restart_busy", clr_busy, 1);
        guard = 0;
        while (clear_writes < 32'hA000 && guard < 10000) begin step(); guard++; end
        check("clr_reach_a000", clear_writes, 32'hA000);

        // back-pressure: head at FFFF is held by the sweep
        for (int i = 0; i < 6; i++) begin
            p_we = 1'b1; p_addr = bp_addr[i]; p_data = DW'(12'h101 + i);
            step();
            check($sformatf("bp_ready_%0d", i), p_ready, (i < 3) ? 1 : 0);
            check($sformatf("bp_drop_%0d", i), p_drop, (i >= 4) ? 1 : 0);
        end
        p_we = 1'b0;
        step();
        check("bp_drop_end", p_drop, 0);

        guard = 0;
        while (done_cnt == 0 && guard < 30000) begin step(); guard++; end
        repeat (8) step();
        check("clr_total_writes", clear_writes, 65536);
        check("clr_sequence_errors", seq_err, 0);
        check("clr_done_count", done_cnt, 1);
        check("clr_done_after_last", done_cyc - last_clr_cyc, 1);
        check("clr_busy_at_done", busy_at_done, 0);
        check("clr_busy_end", clr_busy, 0);
        check("restart_colour_unused", bad_color, 0);
        check("pen_total", pen_a.size(), 6);
        for (int i = 0; i < 4; i++) begin
            if (pen_a.size() > i + 2) begin
                check($sformatf("bp_order_a_%0d", i), pen_a[i+2], bp_addr[i]);
                check($sformatf("bp_order_d_%0d", i), pen_d[i+2], 32'h101 + i);
            end
        end
        check("vmem_8000", vmem[16'h8000], 12'h0DE);
        check("vmem_0050", vmem[16'h0050], 12'hABC);
        check("vmem_ffff", vmem[16'hFFFF], 12'h101);
        check("vmem_1234", vmem[16'h1234], 12'h000);

        // ---- reset mid-clear ----
        reset_mon();
        mon_color = 12'h555;
        clr_color = 12'h555; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        guard = 0;
        while (clear_writes < 32'h1234 && guard < 6000) begin step(); guard++; end
        check("rc_reach_1234", clear_writes, 32'h1234);
        rst = 1'b0;
        #1;
        check("rc_vram_we", vram_we, 0);
        check("rc_vram_a", vram_a, 0);
        check("rc_vram_d", vram_d, 0);
        check("rc_clr_busy", clr_busy, 0);
        check("rc_clr_done", clr_done, 0);
        check("rc_p_ready", p_ready, 0);
        cw_at_rst = clear_writes;
        step();
        step();
        rst = 1'b1;
        repeat (20) step();
        check("rc_no_more_writes", clear_writes, cw_at_rst);
        check("rc_no_done", done_cnt, 0);
        check("rc_busy_after", clr_busy, 0);
        check("rc_ready_after", p_ready, 1);
        check("rc_1234_untouched", vmem[16'h1234], 12'h000);

`ifdef CLR_RECT_EN
        // ---- rectangle clear ----
        reset_mon();
        mon_color = 12'h777;
        clr_color = 12'h777;
        clr_x0 = 8'd10; clr_y0 = 8'd20; clr_x1 = 8'd12; clr_y1 = 8'd21;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (20) step();
        check("rect_count", clr_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (clr_log.size() > i) check($sformatf("rect_a_%0d", i), clr_log[i], rect_exp[i]);
        end
        check("rect_done_count", done_cnt, 1);
        check("rect_done_after_last", done_cyc - last_clr_cyc, 1);

        // empty rectangle: straight to done, no writes
        reset_mon();
        clr_x0 = 8'd5; clr_x1 = 8'd4;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (6) step();
        check("rect_empty_writes", clr_log.size(), 0);
        check("rect_empty_done", done_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
